vfu_result_wb_arbiter: RTL and testbench
========================================

// Module: vfu_result_wb_arbiter
// PURPOSE
// - Lane-side responder for the FU result write-back interface (<fu>_result_req/id/addr/wdata/be -> gnt).
// - Collects write requests from NrReq functional units (ALU, MFPU, ...) and arbitrates them round-robin.
// - Registers the winner into a one-entry output slice and issues it to one VRF write port.
// - Returns a one-cycle gnt to the winning FU.
// PARAMETERS
// - NrReq    2      number of requesting FUs; index 0 = ALU, 1 = MFPU
// - vaddr_t  logic  VRF element address type, same as the lane's
// PORTS
// - clk_i          in   1               clock; single clock domain
// - rst_i          in   1               reset, synchronous, active-high
// - req_i          in   NrReq           per-FU write request
// - req_id_i       in   NrReq x vid_t   per-FU instruction id
// - req_addr_i     in   NrReq x vaddr_t per-FU VRF address
// - req_wdata_i    in   NrReq x elen_t  per-FU write data
// - req_be_i       in   NrReq x strb_t  per-FU byte enables
// - gnt_o          out  NrReq           one-hot, one-cycle grant back to FU
// - vrf_req_o      out  1               VRF write valid (output slice full)
// - vrf_id_o       out  vid_t           id of the write in the slice
// - vrf_addr_o     out  vaddr_t         address of the write in the slice
// - vrf_wdata_o    out  elen_t          data of the write in the slice
// - vrf_be_o       out  strb_t          byte enables of the write in the slice
// - vrf_gnt_i      in   1               VRF accepted the write this cycle
// - conflict_cnt_o out  NrReq x 32      per-FU lost-arbitration cycle counts; only with WB_ARB_STATS_EN
// BEHAVIOUR
// - Reset state: slice empty; all outputs 0; RR pointer = 0; counters = 0.
// - FU protocol: an FU holds req high with a stable payload until it sees gnt.
//   - It may present a new payload the cycle after gnt.
//   - Dropping req or changing payload before gnt is illegal; assertion flags it.
// - can_accept = !vrf_req_o | vrf_gnt_i, so draining and refilling happen in the same cycle.
// - Arbitration, when can_accept and |req_i:
//   - Winner = first requesting index at or after rr_ptr, wrapping modulo NrReq.
//   - gnt_o[winner] = 1 combinationally in this cycle.
//   - The winner's payload is loaded into the slice at the clock edge.
//   - rr_ptr <= winner+1, wrapping NrReq-1 -> 0.
// - When !can_accept or no request: gnt_o = 0 and rr_ptr holds.
// - Latency: FU gnt in cycle N; vrf_req_o high from N+1.
// - Throughput: 1 write/cycle while vrf_gnt_i stays high.
// - Slice state machine:
//   - EMPTY -> FULL on capture.
//   - FULL -> FULL when vrf_gnt_i and capture happen in the same cycle.
//   - FULL -> EMPTY when vrf_gnt_i with no capture.
//   - FULL holds (payload stable) while vrf_gnt_i is low.
// - vrf_gnt_i while the slice is EMPTY is ignored.
// - Slice payload outputs are zeroed when EMPTY.
// - Single requester: it is granted every cycle that can_accept holds; no bubble.
// - Reset asserted mid-operation: the slice write is discarded; gnt_o = 0 in the reset cycle.
//   FUs must also be reset.
// CONFIGURATION
// - Macro WB_ARB_STATS_EN:
//   - Defined: conflict_cnt_o[i] increments when req_i[i] & !gnt_o[i]; saturates at 2^32-1.
//   - Undefined: counters are not built; conflict_cnt_o tied to 0; port list unchanged.
// STRUCTURE
// - ara_pkg: vid_t, elen_t, strb_t (existing).
// - ara_pkg additions: wb_req_t struct {id, addr, wdata, be} and NrWbReq = 2.
// - Sub-module vfu_wb_rr_pick: combinational RR pick from req, rr_ptr -> one-hot grant plus index.
//   The pointer register stays in the parent.
// - Slice and counters stay in the top module.
// TESTING
// - Single FU: ALU req addr 0x10, wdata 0xA5A5, be 0xFF, vrf_gnt_i=1 -> gnt_o=01 in cycle 0.
//   -> vrf_req_o=1 with that payload in cycle 1.
//   - Streaming 8 beats -> 8 consecutive VRF writes, no bubbles.
// - Both FUs requesting continuously with vrf_gnt_i=1 -> grants alternate 01,10,01,10.
//   - Starting after reset, ALU is granted first.
// - Backpressure: vrf_gnt_i=0 for 5 cycles with the slice full -> gnt_o=0 and payload stable.
//   - When vrf_gnt_i rises: drain and refill in the same cycle.
// - Simultaneous drain+capture: slice full and vrf_gnt_i=1 while MFPU requests
//   -> gnt_o=10 that cycle; new payload visible next cycle.
// - Reset mid-stream: rst_i high for 1 cycle with the slice full -> vrf_req_o=0 next cycle.
//   - rr_ptr=0, so ALU wins the first contended cycle.
// - WB_ARB_STATS_EN: 10 cycles of contention with alternating grants -> conflict_cnt_o = {5,5}.
//   - Macro undefined -> conflict_cnt_o = {0,0}.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared lane types plus the FU write-back request format and arbiter constants.
package ara_pkg;

    localparam int unsigned NrVInsn = 8;
    localparam int unsigned ELEN    = 64;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;
    typedef logic [ELEN-1:0]            elen_t;
    typedef logic [ELEN/8-1:0]          strb_t;

    localparam int unsigned NrWbReq     = 2;
    localparam int unsigned WbAddrWidth = 32;

    typedef logic [WbAddrWidth-1:0] wb_addr_t;

    typedef struct packed {
        vid_t     id;
        wb_addr_t addr;
        elen_t    wdata;
        strb_t    be;
    } wb_req_t;

    typedef enum logic {
        SLICE_EMPTY,
        SLICE_FULL
    } slice_state_e;

endpackage

// File: rtl/vfu_result_wb_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr_i, wrapping.
module vfu_wb_rr_pick
    import ara_pkg::*;
#(
    parameter int unsigned NrReq = NrWbReq,
    parameter int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
    input  logic [NrReq-1:0] req_i,
    input  logic [IdxW-1:0]  rr_ptr_i,
    output logic [NrReq-1:0] gnt_o,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned off = 0; off < NrReq; off++) begin
            cand = IdxW'((32'(rr_ptr_i) + off) % NrReq);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vfu_result_wb_arbiter.sv
// Round-robin write-back arbiter: NrReq FUs into a one-entry slice feeding one VRF port.
// Optional macro WB_ARB_STATS_EN builds per-FU saturating lost-arbitration counters.
module vfu_result_wb_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrReq   = NrWbReq,
    parameter type         vaddr_t = logic
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NrReq-1:0]  req_i,
    input  vid_t              req_id_i    [NrReq],
    input  vaddr_t            req_addr_i  [NrReq],
    input  elen_t             req_wdata_i [NrReq],
    input  strb_t             req_be_i    [NrReq],
    output logic [NrReq-1:0]  gnt_o,
    output logic              vrf_req_o,
    output vid_t              vrf_id_o,
    output vaddr_t            vrf_addr_o,
    output elen_t             vrf_wdata_o,
    output strb_t             vrf_be_o,
    input  logic              vrf_gnt_i,
    output logic [31:0]       conflict_cnt_o [NrReq]
);

    localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

    // Same layout as wb_req_t, but the address keeps the lane's own width.
    typedef struct packed {
        vid_t   id;
        vaddr_t addr;
        elen_t  wdata;
        strb_t  be;
    } slot_t;

    slice_state_e    state_q, state_d;
    slot_t           slot_q, slot_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic [NrReq-1:0] pick_gnt;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_valid;
    logic             can_accept;
    logic             capture;

    vfu_wb_rr_pick #(
        .NrReq (NrReq),
        .IdxW  (IdxW)
    ) i_rr_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .gnt_o    (pick_gnt),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        can_accept = (state_q == SLICE_EMPTY) || vrf_gnt_i;
        capture    = can_accept && pick_valid && !rst_i;
        gnt_o      = capture ? pick_gnt : '0;

        state_d  = state_q;
        slot_d   = slot_q;
        rr_ptr_d = rr_ptr_q;

        if (capture) begin
            state_d      = SLICE_FULL;
            slot_d.id    = req_id_i[pick_idx];
            slot_d.addr  = req_addr_i[pick_idx];
            slot_d.wdata = req_wdata_i[pick_idx];
            slot_d.be    = req_be_i[pick_idx];
            rr_ptr_d     = (pick_idx == IdxW'(NrReq - 1)) ? '0 : IdxW'(pick_idx + 1'b1);
        end else if (state_q == SLICE_FULL && vrf_gnt_i) begin
            state_d = SLICE_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SLICE_EMPTY;
            slot_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        vrf_req_o   = (state_q == SLICE_FULL);
        vrf_id_o    = vrf_req_o ? slot_q.id    : '0;
        vrf_addr_o  = vrf_req_o ? slot_q.addr  : '0;
        vrf_wdata_o = vrf_req_o ? slot_q.wdata : '0;
        vrf_be_o    = vrf_req_o ? slot_q.be    : '0;
    end

`ifdef WB_ARB_STATS_EN
    logic [31:0] cnt_q [NrReq];
    logic [31:0] cnt_d [NrReq];

    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            cnt_d[i] = cnt_q[i];
            if (req_i[i] && !gnt_o[i] && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            if (rst_i) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            conflict_cnt_o[i] = cnt_q[i];
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NrReq; i++) begin
            conflict_cnt_o[i] = '0;
        end
    end
`endif

    // An FU must keep req and payload steady until it is granted.
    for (genvar g = 0; g < NrReq; g++) begin : g_fu_proto
        fu_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_i[g] && !gnt_o[g]) |=> (req_i[g]
                && $stable(req_id_i[g]) && $stable(req_addr_i[g])
                && $stable(req_wdata_i[g]) && $stable(req_be_i[g])));
    end

endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// Scoreboard bench: stimulus queues expected VRF writes, a monitor checks each accepted write.
module tb_vfu_result_wb_arbiter;
    import ara_pkg::*;

    typedef logic [9:0] tb_addr_t;

    typedef struct packed {
        vid_t     id;
        tb_addr_t addr;
        elen_t    wdata;
        strb_t    be;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    vid_t       id    [2];
    tb_addr_t   addr  [2];
    elen_t      wdata [2];
    strb_t      be    [2];
    logic [1:0] gnt;
    logic       vrf_req;
    vid_t       vrf_id;
    tb_addr_t   vrf_addr;
    elen_t      vrf_wdata;
    strb_t      vrf_be;
    logic       vrf_gnt;
    logic [31:0] cnt [2];

    int   checks   = 0;
    int   failures = 0;
    int   wr_cnt   = 0;
    exp_t exp_q[$];

`ifdef WB_ARB_STATS_EN
    localparam logic [31:0] ExpConflict = 32'd5;
`else
    localparam logic [31:0] ExpConflict = 32'd0;
`endif

    always #5 clk = ~clk;

    vfu_result_wb_arbiter #(
        .NrReq   (2),
        .vaddr_t (tb_addr_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .req_id_i       (id),
        .req_addr_i     (addr),
        .req_wdata_i    (wdata),
        .req_be_i       (be),
        .gnt_o          (gnt),
        .vrf_req_o      (vrf_req),
        .vrf_id_o       (vrf_id),
        .vrf_addr_o     (vrf_addr),
        .vrf_wdata_o    (vrf_wdata),
        .vrf_be_o       (vrf_be),
        .vrf_gnt_i      (vrf_gnt),
        .conflict_cnt_o (cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int f, input vid_t i, input tb_addr_t a, input elen_t d, input strb_t b);
        id[f]    = i;
        addr[f]  = a;
        wdata[f] = d;
        be[f]    = b;
    endtask

    task automatic push(input int f);
        exp_t e;
        e.id    = id[f];
        e.addr  = addr[f];
        e.wdata = wdata[f];
        e.be    = be[f];
        exp_q.push_back(e);
    endtask

    // Monitor: every write the VRF accepts must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && vrf_req && vrf_gnt) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got write addr 0x%0h with no expected entry", vrf_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_id",    64'(vrf_id),    64'(e.id));
                    chk("wb_addr",  64'(vrf_addr),  64'(e.addr));
                    chk("wb_wdata", vrf_wdata,      e.wdata);
                    chk("wb_be",    64'(vrf_be),    64'(e.be));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int wr_start;

        rst     = 1'b1;
        req     = '0;
        vrf_gnt = 1'b0;
        for (int f = 0; f < 2; f++) set_fu(f, '0, '0, '0, '0);
        repeat (2) @(posedge clk);

        // Reset state; vrf_gnt_i with an empty slice must be ignored.
        #1;
        rst     = 1'b0;
        vrf_gnt = 1'b1;
        #3;
        chk("rst_vrf_req", 64'(vrf_req), 64'd0);
        chk("rst_id",      64'(vrf_id), 64'd0);
        chk("rst_addr",    64'(vrf_addr), 64'd0);
        chk("rst_wdata",   vrf_wdata, 64'd0);
        chk("rst_be",      64'(vrf_be), 64'd0);
        chk("rst_gnt",     64'(gnt), 64'd0);
        chk("rst_cnt0",    64'(cnt[0]), 64'd0);
        chk("rst_cnt1",    64'(cnt[1]), 64'd0);
        cyc();
        #3;
        chk("empty_gnt_ignored", 64'(vrf_req), 64'd0);

        // Single ALU streaming 8 beats with the VRF always ready.
        wr_start = wr_cnt;
        for (int k = 0; k < 8; k++) begin
            cyc();
            req = 2'b01;
            set_fu(0, 3'(k), 10'h010 + 10'(k), 64'hA5A5 + 64'(k), 8'hFF);
            #3;
            chk("single_gnt", 64'(gnt), 64'b01);
            push(0);
            if (k > 0) chk("single_no_bubble", 64'(vrf_req), 64'd1);
            if (k == 1) begin
                chk("single_lat_addr",  64'(vrf_addr), 64'h010);
                chk("single_lat_wdata", vrf_wdata, 64'hA5A5);
                chk("single_lat_be",    64'(vrf_be), 64'hFF);
            end
        end
        cyc();
        req = '0;
        #3;
        chk("single_last_req", 64'(vrf_req), 64'd1);
        cyc();
        #3;
        chk("single_drained", 64'(vrf_req), 64'd0);
        chk("single_wr_count", 64'(wr_cnt - wr_start), 64'd8);

        // Fill the slice, then reset mid-stream: the write must vanish.
        cyc();
        vrf_gnt = 1'b0;
        req     = 2'b10;
        set_fu(1, 3'd5, 10'h2A0, 64'hDEAD_0001, 8'h0F);
        #3;
        chk("pre_rst_gnt", 64'(gnt), 64'b10);
        cyc();
        rst     = 1'b1;
        req     = 2'b01;
        vrf_gnt = 1'b1;
        set_fu(0, 3'd1, 10'h100, 64'h1000, 8'hFF);
        #3;
        chk("rst_cycle_full", 64'(vrf_req), 64'd1);
        chk("rst_cycle_gnt",  64'(gnt), 64'd0);

        // Both FUs contend after reset: ALU first, then strict alternation.
        cyc();
        rst = 1'b0;
        req = 2'b11;
        set_fu(1, 3'd2, 10'h200, 64'h2000, 8'hF0);
        #3;
        chk("rst_discard", 64'(vrf_req), 64'd0);
        wr_start = wr_cnt;
        for (int k = 0; k < 10; k++) begin
            w = k % 2;
            chk("rr_gnt", 64'(gnt), (w == 1) ? 64'b10 : 64'b01);
            push(w);
            cyc();
            set_fu(w, 3'(k + 3), addr[w] + 10'd1, wdata[w] + 64'd1, be[w]);
            if (k == 9) req = 2'b01;
            #3;
            chk("rr_stream_req", 64'(vrf_req), 64'd1);
        end
        chk("rr_tail_gnt", 64'(gnt), 64'b01);
        push(0);
        cyc();
        req = '0;
        #3;
        chk("conflict_cnt0", 64'(cnt[0]), 64'(ExpConflict));
        chk("conflict_cnt1", 64'(cnt[1]), 64'(ExpConflict));

        // Backpressure: slice full and VRF stalled for 5 cycles.
        cyc();
        vrf_gnt = 1'b0;
        req     = 2'b01;
        set_fu(0, 3'd6, 10'h3C0, 64'hCAFE_F00D, 8'h3C);
        #3;
        chk("rr_wr_count", 64'(wr_cnt - wr_start), 64'd11);
        chk("bp_capture_gnt", 64'(gnt), 64'b01);
        push(0);
        for (int j = 0; j < 5; j++) begin
            cyc();
            if (j == 0) set_fu(0, 3'd7, 10'h3C1, 64'h0000_BEEF, 8'hC3);
            #3;
            chk("bp_gnt",   64'(gnt), 64'd0);
            chk("bp_req",   64'(vrf_req), 64'd1);
            chk("bp_addr",  64'(vrf_addr), 64'h3C0);
            chk("bp_wdata", vrf_wdata, 64'hCAFE_F00D);
        end
        cyc();
        vrf_gnt = 1'b1;
        #3;
        chk("bp_refill_gnt", 64'(gnt), 64'b01);
        push(0);
        cyc();
        req = '0;
        #3;
        chk("bp_next_req",  64'(vrf_req), 64'd1);
        chk("bp_next_addr", 64'(vrf_addr), 64'h3C1);

        // Drain and MFPU capture in the same cycle.
        cyc();
        req = 2'b01;
        set_fu(0, 3'd0, 10'h050, 64'h5555, 8'h01);
        #3;
        chk("dc_alu_gnt", 64'(gnt), 64'b01);
        push(0);
        cyc();
        req = 2'b10;
        set_fu(1, 3'd4, 10'h060, 64'h6666, 8'h80);
        #3;
        chk("dc_full", 64'(vrf_req), 64'd1);
        chk("dc_gnt",  64'(gnt), 64'b10);
        push(1);
        cyc();
        req = '0;
        #3;
        chk("dc_next_req",   64'(vrf_req), 64'd1);
        chk("dc_next_addr",  64'(vrf_addr), 64'h060);
        chk("dc_next_wdata", vrf_wdata, 64'h6666);
        cyc();
        #3;
        chk("dc_drained", 64'(vrf_req), 64'd0);

        repeat (2) cyc();
        chk("sb_empty",       64'(exp_q.size()), 64'd0);
        chk("total_wr_count", 64'(wr_cnt), 64'd23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
